// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the pipeline's memory stage (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a request/response handshake with a fixed
// read latency; defining MEM_RAND_LAT_EN adds 0..7 LFSR-driven extra cycles per read.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      lat_cnt;
  logic [CNT_W-1:0]      lat_load;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0]           rd_data_q;
  logic [31:0]           mem [DEPTH];
  logic                  req_ready;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  unused_addr_bits;

  assign req_idx          = bus.Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{bus.Address[31:ADDR_WIDTH+2], bus.Address[1:0]};

  assign req_ready           = (state == IDLE) && !rst;
  assign wr_fire             = req_ready && bus.MemWrite;
  assign rd_fire             = req_ready && bus.MemRead && !bus.MemWrite;
  assign bus.Mem_Req_Ready   = req_ready;
  assign bus.Read_data       = rd_data_q;
  assign bus.Read_data_Valid = (state == RESP);

`ifdef MEM_RAND_LAT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_comb begin
    lat_load = CNT_W'(READ_LATENCY - 1) + CNT_W'(lfsr[2:0]);
  end
`else
  always_comb begin
    lat_load = CNT_W'(READ_LATENCY - 1);
  end
`endif

  // RAM has no reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.Write_strb[i]) mem[req_idx][8*i +: 8] <= bus.Write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_idx    <= '0;
      rd_data_q <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_fire) begin
            wr_cnt <= wr_cnt + 32'd1;
          end else if (rd_fire) begin
            rd_idx  <= req_idx;
            lat_cnt <= lat_load;
            // Single-cycle latency fetches the word on the acceptance edge itself.
            if (lat_load == '0) begin
              rd_data_q <= mem[req_idx];
              state     <= RESP;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          if (lat_cnt == CNT_W'(1)) begin
            rd_data_q <= mem[rd_idx];
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.Read_data_Ready) begin
            rd_cnt <= rd_cnt + 32'd1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder against a word-array model.
module tb_data_mem_responder;
  localparam int unsigned AW = 12;
  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  int          tests  = 0;
  int          failed = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic [31:0] ref_mem [1 << AW];

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % (1 << AW);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.Address    = '0;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.Write_data = '0;
    bus.Write_strb = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned k;
    check("wr_ready", {31'd0, bus.Mem_Req_Ready}, 32'd1);
    bus.Address    = a;
    bus.Write_data = d;
    bus.Write_strb = s;
    bus.MemWrite   = 1'b1;
    tick();
    idle_inputs();
    k = widx(a);
    for (int i = 0; i < 4; i++) if (s[i]) ref_mem[k][8*i +: 8] = d[8*i +: 8];
    exp_wr++;
    check("wr_cnt", wr_cnt, exp_wr);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall, output int lat);
    logic [31:0] held;
    int n;
    check("rd_ready", {31'd0, bus.Mem_Req_Ready}, 32'd1);
    bus.Address         = a;
    bus.MemRead         = 1'b1;
    bus.Read_data_Ready = (stall == 0);
    tick();
    idle_inputs();
    n = 1;
    while (!bus.Read_data_Valid && n < 64) begin
      check("rd_wait_ready", {31'd0, bus.Mem_Req_Ready}, 32'd0);
      tick();
      n++;
    end
    lat = n;
    check("rd_valid", {31'd0, bus.Read_data_Valid}, 32'd1);
    check("rd_data", bus.Read_data, ref_mem[widx(a)]);
    held = bus.Read_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", {31'd0, bus.Read_data_Valid}, 32'd1);
      check("stall_data", bus.Read_data, held);
      check("stall_ready", {31'd0, bus.Mem_Req_Ready}, 32'd0);
    end
    bus.Read_data_Ready = 1'b1;
    tick();
    bus.Read_data_Ready = 1'b0;
    exp_rd++;
    check("rd_cnt", rd_cnt, exp_rd);
    check("post_ready", {31'd0, bus.Mem_Req_Ready}, 32'd1);
    check("post_valid", {31'd0, bus.Read_data_Valid}, 32'd0);
  endtask

  task automatic check_latency(input int lat);
`ifdef MEM_RAND_LAT_EN
    check("lat_range", {31'd0, (lat >= RL) && (lat <= RL + 7)}, 32'd1);
`else
    check("latency", lat, RL);
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int min_lat;
    int max_lat;
    logic [31:0] a;
    logic [31:0] q[$];

    rst = 1'b1;
    idle_inputs();
    bus.Read_data_Ready = 1'b0;

    repeat (2) begin
      tick();
      check("rst_ready", {31'd0, bus.Mem_Req_Ready}, 32'd0);
      check("rst_valid", {31'd0, bus.Read_data_Valid}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("init_ready", {31'd0, bus.Mem_Req_Ready}, 32'd1);
    check("init_valid", {31'd0, bus.Read_data_Valid}, 32'd0);
    check("init_rd_cnt", rd_cnt, 32'd0);
    check("init_wr_cnt", wr_cnt, 32'd0);

    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10, 0, lat);
    check_latency(lat);
    check("first_rd_cnt", rd_cnt, 32'd1);
    check("first_wr_cnt", wr_cnt, 32'd1);

    do_write(32'h10, 32'h11223344, 4'b0101);
    do_read(32'h10, 0, lat);
    check_latency(lat);

    do_read(32'h10, 5, lat);
    check_latency(lat);

    // simultaneous write+read: write only, no response
    bus.Address    = 32'h20;
    bus.Write_data = 32'h5;
    bus.Write_strb = 4'hF;
    bus.MemWrite   = 1'b1;
    bus.MemRead    = 1'b1;
    tick();
    idle_inputs();
    ref_mem[widx(32'h20)] = 32'h5;
    exp_wr++;
    repeat (RL + 10) begin
      check("both_no_valid", {31'd0, bus.Read_data_Valid}, 32'd0);
      check("both_ready", {31'd0, bus.Mem_Req_Ready}, 32'd1);
      tick();
    end
    check("both_wr_cnt", wr_cnt, exp_wr);
    check("both_rd_cnt", rd_cnt, exp_rd);
    do_read(32'h20, 0, lat);

    do_write(32'h4010, 32'hCAFEF00D, 4'hF);
    do_read(32'h10, 1, lat);

    do_write(32'h10, 32'h12345678, 4'h0);
    do_read(32'h10, 0, lat);

    q.push_back(32'h10);
    q.push_back(32'h20);
    repeat (60) begin
      case ($urandom_range(0, 2))
        0: begin
          a = $urandom;
          do_write(a, $urandom, 4'hF);
          q.push_back(a);
        end
        1: do_write(q[$urandom_range(0, q.size() - 1)], $urandom, 4'($urandom_range(0, 15)));
        default: begin
          do_read(q[$urandom_range(0, q.size() - 1)], $urandom_range(0, 2), lat);
          check_latency(lat);
        end
      endcase
    end

    // reset while the read is still waiting: response must vanish
    bus.Address         = 32'h20;
    bus.MemRead         = 1'b1;
    bus.Read_data_Ready = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.Mem_Req_Ready}, 32'd0);
    tick();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    repeat (RL + 10) begin
      tick();
      check("midrst_no_valid", {31'd0, bus.Read_data_Valid}, 32'd0);
      check("midrst_idle", {31'd0, bus.Mem_Req_Ready}, 32'd1);
    end
    bus.Read_data_Ready = 1'b0;
    check("midrst_rd_cnt", rd_cnt, 32'd0);
    check("midrst_wr_cnt", wr_cnt, 32'd0);
    do_read(32'h20, 0, lat);
    do_read(32'h10, 0, lat);

`ifdef MEM_RAND_LAT_EN
    min_lat = 1000;
    max_lat = 0;
    repeat (100) begin
      do_read(q[$urandom_range(0, q.size() - 1)], 0, lat);
      check_latency(lat);
      if (lat < min_lat) min_lat = lat;
      if (lat > max_lat) max_lat = lat;
    end
    check("lat_min_hit", min_lat, RL);
    check("lat_max_hit", max_lat, RL + 7);
`else
    min_lat = 0;
    max_lat = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
